memory_arbiter: RTL and testbench

Three-port memory arbiter and access sequencer for the Geriatrics memory controller. It grants one of three requesters (instruction fetch, data load/store, peripheral/DMA) exclusive use of the shared memory bus in round-robin order. It drives the bus strobes for a programmable number of wait states, then returns a one-cycle completion pulse with read data. An internal countdown of the wait states replaces per-requester completion counting.

---
 rtl/memory_arbiter.sv | 112 +++++++++++
 tb/tb_memory_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/memory_arbiter.sv
// Three-port round-robin memory arbiter: grants one requester the shared bus,
// holds the strobes for wait_max+1 cycles, then pulses done with captured read data.
module memory_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2:0]            req,
  input  logic [2:0]            req_wen,
  input  logic [2:0]            req_ren,
  input  logic [3*ADDR_W-1:0]   req_addr,
  input  logic [3*DATA_W-1:0]   req_wdata,
  input  logic [3:0]            wait_max,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic                  mem_wen,
  output logic                  mem_ren,
  output logic [2:0]            grant,
  output logic [2:0]            done,
  output logic [DATA_W-1:0]     rdata,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t      state;
  logic [3:0]  count;
  logic [1:0]  last;

  logic [2:0]  eligible;
  logic [1:0]  cand0;
  logic [1:0]  cand1;
  logic        win_valid;
  logic [1:0]  win_idx;

  assign eligible = req & (req_wen | req_ren);

  // Search order last+1, last+2, last (mod 3); the loop runs lowest priority
  // first so the highest-priority eligible candidate is the final assignment.
  always_comb begin
    cand0     = (last == 2'd2) ? 2'd0 : last + 2'd1;
    cand1     = (cand0 == 2'd2) ? 2'd0 : cand0 + 2'd1;
    win_valid = 1'b0;
    win_idx   = 2'd0;
    if (eligible[last]) begin
      win_valid = 1'b1;
      win_idx   = last;
    end
    if (eligible[cand1]) begin
      win_valid = 1'b1;
      win_idx   = cand1;
    end
    if (eligible[cand0]) begin
      win_valid = 1'b1;
      win_idx   = cand0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      grant     <= '0;
      done      <= '0;
      busy      <= 1'b0;
      mem_wen   <= 1'b0;
      mem_ren   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rdata     <= '0;
      count     <= '0;
      last      <= 2'd2;
    end else begin
      case (state)
        IDLE: begin
          done <= '0;
          if (win_valid) begin
            grant     <= 3'b001 << win_idx;
            mem_addr  <= req_addr[win_idx*ADDR_W +: ADDR_W];
            mem_wdata <= req_wdata[win_idx*DATA_W +: DATA_W];
            mem_wen   <= req_wen[win_idx];
            mem_ren   <= ~req_wen[win_idx];
            count     <= wait_max;
            last      <= win_idx;
            busy      <= 1'b1;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          if (count != 4'd0) begin
            count <= count - 4'd1;
          end else begin
            if (mem_ren) rdata <= mem_rdata;
            mem_wen <= 1'b0;
            mem_ren <= 1'b0;
            done    <= grant;
            state   <= DONE;
          end
        end
        DONE: begin
          done  <= '0;
          grant <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: a table of single transactions plus
// hand-written back-to-back, contention and mid-access reset sequences.
module tb_memory_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [2:0]   req;
  logic [2:0]   req_wen;
  logic [2:0]   req_ren;
  logic [95:0]  req_addr;
  logic [95:0]  req_wdata;
  logic [3:0]   wait_max;
  logic [31:0]  mem_rdata;
  logic [31:0]  mem_addr;
  logic [31:0]  mem_wdata;
  logic         mem_wen;
  logic         mem_ren;
  logic [2:0]   grant;
  logic [2:0]   done;
  logic [31:0]  rdata;
  logic         busy;

  int checks = 0;
  int errors = 0;

  memory_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .req(req), .req_wen(req_wen), .req_ren(req_ren),
    .req_addr(req_addr), .req_wdata(req_wdata), .wait_max(wait_max),
    .mem_rdata(mem_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wen(mem_wen), .mem_ren(mem_ren), .grant(grant), .done(done),
    .rdata(rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  req;
    logic [2:0]  wen;
    logic [2:0]  ren;
    logic [95:0] addr;
    logic [95:0] wdata;
    logic [3:0]  wm;
    logic [31:0] mrd;
    logic [2:0]  grant_e;
    logic        wr_e;
    logic [31:0] addr_e;
    logic [31:0] wdata_e;
    logic [31:0] rdata_e;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req = '0; req_wen = '0; req_ren = '0;
    req_addr = '0; req_wdata = '0; wait_max = '0; mem_rdata = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Called at a negedge with the DUT idle; the next edge is the grant edge.
  task automatic run_vec(input int n, input vec_t v);
    int gcnt = 0, wcnt = 0, rcnt = 0, dcnt = 0, first_k = -1, bad = 0;
    logic [2:0]  dval = '0;
    logic [31:0] rd_at = '0;
    logic        seen = 1'b0;
    req = v.req; req_wen = v.wen; req_ren = v.ren;
    req_addr = v.addr; req_wdata = v.wdata; wait_max = v.wm; mem_rdata = v.mrd;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (grant != 3'b000) begin
        if (!seen) begin
          seen = 1'b1;
          first_k = k;
          check($sformatf("v%0d first_grant", n), {29'd0, grant}, {29'd0, v.grant_e});
          check($sformatf("v%0d mem_addr", n), mem_addr, v.addr_e);
          check($sformatf("v%0d mem_wdata", n), mem_wdata, v.wdata_e);
          // Dropping req and changing wait_max must not shorten or stretch the access.
          req = '0; req_wen = '0; req_ren = '0; wait_max = 4'hF;
        end
        gcnt++;
        if (grant !== v.grant_e || busy !== 1'b1) bad++;
      end
      if (mem_wen) wcnt++;
      if (mem_ren) rcnt++;
      if (done != 3'b000) begin
        dcnt++;
        dval = done;
        rd_at = rdata;
        if (mem_wen || mem_ren) bad++;
      end
      if (seen && grant == 3'b000) break;
    end
    check($sformatf("v%0d grant_latency", n), first_k, 0);
    check($sformatf("v%0d grant_cycles", n), gcnt, v.wm + 2);
    check($sformatf("v%0d grant_busy_stable", n), bad, 0);
    check($sformatf("v%0d wen_cycles", n), wcnt, v.wr_e ? v.wm + 1 : 0);
    check($sformatf("v%0d ren_cycles", n), rcnt, v.wr_e ? 0 : v.wm + 1);
    check($sformatf("v%0d done_pulses", n), dcnt, 1);
    check($sformatf("v%0d done_value", n), {29'd0, dval}, {29'd0, v.grant_e});
    check($sformatf("v%0d rdata", n), rd_at, v.rdata_e);
    check($sformatf("v%0d busy_after", n), {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] exp_tr[16];
    int rises[$];
    int dcnt;
    logic [2:0] prev;

    vecs[0] = '{3'b010, 3'b000, 3'b010, {32'h300, 32'h100, 32'h0}, {32'h3, 32'h2, 32'h1},
                4'd2, 32'hCAFEF00D, 3'b010, 1'b0, 32'h100, 32'h2, 32'hCAFEF00D};
    vecs[1] = '{3'b100, 3'b100, 3'b100, {32'h20, 32'h111, 32'h222}, {32'h55AA, 32'h1, 32'h2},
                4'd3, 32'h12345678, 3'b100, 1'b1, 32'h20, 32'h55AA, 32'hCAFEF00D};
    vecs[2] = '{3'b011, 3'b000, 3'b010, {32'h0, 32'h204, 32'h208}, {32'h0, 32'h77, 32'h66},
                4'd1, 32'hA5A50001, 3'b010, 1'b0, 32'h204, 32'h77, 32'hA5A50001};
    vecs[3] = '{3'b001, 3'b000, 3'b001, {32'h0, 32'h0, 32'h40}, {32'h0, 32'h0, 32'h9},
                4'd0, 32'hDEADBEEF, 3'b001, 1'b0, 32'h40, 32'h9, 32'hDEADBEEF};
    vecs[4] = '{3'b111, 3'b000, 3'b111, {32'hC, 32'hB, 32'hA}, {32'h3, 32'h2, 32'h1},
                4'd2, 32'h0BADF00D, 3'b010, 1'b0, 32'hB, 32'h2, 32'h0BADF00D};
    vecs[5] = '{3'b101, 3'b101, 3'b000, {32'h500, 32'h0, 32'h400}, {32'hBEEF, 32'h0, 32'hF00D},
                4'd0, 32'hFFFFFFFF, 3'b100, 1'b1, 32'h500, 32'hBEEF, 32'h0BADF00D};
    vecs[6] = '{3'b011, 3'b000, 3'b011, {32'h0, 32'h610, 32'h600}, {32'h0, 32'h22, 32'h11},
                4'd4, 32'h11112222, 3'b001, 1'b0, 32'h600, 32'h11, 32'h11112222};

    rst = 1'b1;
    do_reset();
    @(negedge clk);
    check("reset grant", {29'd0, grant}, 32'd0);
    check("reset done", {29'd0, done}, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset strobes", {30'd0, mem_wen, mem_ren}, 32'd0);
    check("reset mem_addr", mem_addr, 32'd0);
    check("reset mem_wdata", mem_wdata, 32'd0);
    check("reset rdata", rdata, 32'd0);

    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // Zero wait states, request held: grant rises every 3 cycles.
    req = 3'b001; req_wen = 3'b000; req_ren = 3'b001; wait_max = 4'd0;
    req_addr = {32'h0, 32'h0, 32'h80}; mem_rdata = 32'h00C0FFEE;
    prev = 3'b000;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (prev == 3'b000 && grant != 3'b000) rises.push_back(k);
      if (k == 0) check("zw strobe_k0", {31'd0, mem_ren}, 32'd1);
      if (k == 1) begin
        check("zw strobe_k1", {31'd0, mem_ren}, 32'd0);
        check("zw done_k1", {29'd0, done}, 32'd1);
        check("zw rdata_k1", rdata, 32'h00C0FFEE);
      end
      prev = grant;
    end
    check("zw rise_count", rises.size(), 4);
    if (rises.size() >= 2) check("zw period", rises[1] - rises[0], 3);

    // Contention from reset: grants 0,1,2 then requester 0 again.
    do_reset();
    req = 3'b111; req_ren = 3'b111; wait_max = 4'd1; mem_rdata = 32'h5A5A5A5A;
    exp_tr = '{3'd1, 3'd1, 3'd1, 3'd0, 3'd2, 3'd2, 3'd2, 3'd0,
               3'd4, 3'd4, 3'd4, 3'd0, 3'd1, 3'd1, 3'd1, 3'd0};
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      check($sformatf("cont grant_k%0d", k), {29'd0, grant}, {29'd0, exp_tr[k]});
      if (done != 3'b000) req = req & ~done;
      if (done[2]) req[0] = 1'b1;
    end
    req = '0; req_ren = '0;

    // Reset in the second ACCESS cycle of a long read.
    @(negedge clk);
    req = 3'b010; req_ren = 3'b010; wait_max = 4'd5;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid grant", {29'd0, grant}, 32'd0);
    check("rst_mid done", {29'd0, done}, 32'd0);
    check("rst_mid busy", {31'd0, busy}, 32'd0);
    check("rst_mid strobes", {30'd0, mem_wen, mem_ren}, 32'd0);
    check("rst_mid mem_addr", mem_addr, 32'd0);
    check("rst_mid rdata", rdata, 32'd0);
    rst = 1'b0; req = '0; req_ren = '0;
    dcnt = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done != 3'b000) dcnt++;
    end
    check("rst_mid no_done", dcnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
